jedro_1_mtimer: RTL and testbench
=================================

# jedro_1_mtimer

Memory-mapped RISC-V machine timer for the jedro_1 core. It sits downstream of the core's data-memory port as a peripheral slave and upstream of the CSR unit's timer interrupt input. It holds the 64-bit `mtime` and `mtimecmp` registers and a programmable prescaler. It drives a level-sensitive timer interrupt request while the timer is enabled and `mtime >= mtimecmp`.

## Interface

**Parameters**

- `DATA_WIDTH`, 32: bus data width. Only 32 is supported.
- `PRESCALE_WIDTH`, 8: width of the prescaler divide field and its counter.

**Ports**

- `clk_i` — input, 1: core clock.
- `rst_i` — input, 1: reset. One clock domain; reset is synchronous and active-high.
- `en_i` — input, 1: bus access request, valid for one cycle.
- `we_i` — input, 4: byte write enables. All zero means a read.
- `addr_i` — input, 5: byte offset within the block, word aligned.
- `wdata_i` — input, 32: write data.
- `rdata_ro` — output, 32: registered read data.
- `rvalid_ro` — output, 1: one-cycle pulse. Marks `rdata_ro` valid, and also acknowledges writes.
- `err_ro` — output, 1: one-cycle pulse with `rvalid_ro` when the address is unmapped or misaligned.
- `timer_irq_ro` — output, 1: machine timer interrupt request, level, registered.

## Operation

**Register map (byte offsets)**

- 0x00: `mtime[31:0]`
- 0x04: `mtime[63:32]`
- 0x08: `mtimecmp[31:0]`
- 0x0C: `mtimecmp[63:32]`
- 0x10: `CTRL`
  - bit 0 = `EN`
  - bits [8+PRESCALE_WIDTH-1:8] = `DIV`
  - all other bits read 0 and ignore writes.
- 0x14–0x1C: unmapped.

**Bus access**

- Every access with `en_i=1` is acknowledged the next cycle with `rvalid_ro=1`. There are no wait states.
- Reads:
  - Return the register value as it stood in the request cycle, before that cycle's update.
  - Unmapped offsets return 0 and pulse `err_ro`.
- Writes:
  - Per byte lane; lanes with `we_i[n]=0` keep their value.
  - Writes to unmapped offsets are ignored and pulse `err_ro`.
- `addr_i[1:0]!=0` is treated as unmapped: write ignored, read returns 0, `err_ro` pulses.

**Prescaler**

- `pcnt` is `PRESCALE_WIDTH` bits wide.
- While `EN=1`:
  - If `pcnt==DIV`: `pcnt` is set to 0 and `mtime` increments by 1 (tick).
  - Otherwise `pcnt` increments.
- Result: `mtime` advances once every `DIV+1` cycles. `DIV=0` means once per cycle.
- While `EN=0`, `pcnt` and `mtime` hold.
- Any write to `CTRL` clears `pcnt` to 0, and that cycle produces no tick.

**Counter**

- `mtime` is a full 64-bit incrementer. It wraps from 0xFFFF_FFFF_FFFF_FFFF to 0, with carry propagating from the low word into the high word in the same cycle.
- A write to either `mtime` word in a cycle suppresses that cycle's tick. The written bytes take `wdata_i`, and all other bytes of `mtime` keep their pre-tick value.
- Software must handle 32-bit read tearing (hi/lo/hi sequence). The block does not latch a snapshot.

**Interrupt**

- `timer_irq_ro` is registered each cycle to `EN && (mtime >= mtimecmp)`, using the current register values and an unsigned 64-bit compare.
- It stays high until software raises `mtimecmp`, lowers `mtime`, or clears `EN`.

## Timing

**Reset values**

- Registers: `mtime=0`, `mtimecmp=0xFFFF_FFFF_FFFF_FFFF`, `CTRL=0`, `pcnt=0`.
- Outputs: `rdata_ro=0`, `rvalid_ro=0`, `err_ro=0`, `timer_irq_ro=0`.

**Reset mid-operation**

- Reset during a pending access drops it: no `rvalid_ro` follows.
- Reset overrides every simultaneous write or tick.

**Latency**

- Read or write: request in cycle N, `rvalid_ro`/`rdata_ro`/`err_ro` in cycle N+1.
- Written values are visible to a read issued in cycle N+1.
- Interrupt: if `mtime >= mtimecmp` first holds after the clock edge ending cycle N, `timer_irq_ro` is high in cycle N+1. Deassertion follows the same one-cycle rule.

**Back-to-back accesses**

- Accesses are accepted every cycle.
- `rvalid_ro` may stay high continuously, with one pulse per request.

**Simultaneous events**

- Writing `mtimecmp` in the same cycle as a tick: both take effect. The compare uses both new values one cycle later.
- Writing `CTRL.EN=0` in a tick cycle: no tick, because the `CTRL` write clears `pcnt`.

## Test plan

- **Reset values:** assert `rst_i` for 2 cycles, then read 0x00/0x04/0x08/0x0C/0x10 → data 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0; `timer_irq_ro=0` throughout.
- **Basic interrupt:** write `mtimecmp` = 5 (lo = 5, hi = 0), then `CTRL` = 0x1 (`DIV=0`) → `mtime` reads 3 after 3 cycles; `timer_irq_ro` rises exactly one cycle after `mtime` becomes 5; writing `mtimecmp` lo = 100 drops the irq one cycle later.
- **Prescaler:** write `CTRL` = 0x0301 (`DIV=3`) → `mtime` increments every 4 cycles; after 40 cycles it reads 10. Rewriting `CTRL` mid-period restarts the 4-cycle count.
- **Wrap and carry:** write `mtime` lo = 0xFFFFFFFF and hi = 0xFFFFFFFF, then enable with `DIV=0` → `mtime` reads 0/0 after one tick. Separately, lo = 0xFFFFFFFF with hi = 0 → hi reads 1 after one tick.
- **Byte lanes and write-vs-tick:** while running, write `mtime` lo with `we_i=4'b0010`, `wdata_i=0x0000AB00` → only byte 1 becomes 0xAB, other bytes unchanged, no increment that cycle.
- **Unmapped or misaligned access:** write 0x14 → `err_ro` and `rvalid_ro` pulse together, no register changes; read 0x02 → `rdata_ro=0`, `err_ro=1`.

Source files
------------

// File: rtl/jedro_1_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp, prescaled tick and a level timer
// interrupt, exposed as a single-cycle memory-mapped slave on the data bus.
module jedro_1_mtimer #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [4:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_ro,
    output logic                  rvalid_ro,
    output logic                  err_ro,
    output logic                  timer_irq_ro
);

    // Word index (addr_i[4:2]) of each mapped register.
    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4
    } reg_idx_e;

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Replace only the byte lanes whose write enable is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_en;
    logic [PRESCALE_WIDTH-1:0] r_div;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;

    logic                      w_aligned;
    logic [2:0]                w_word;
    logic                      w_mapped;
    logic                      w_is_write;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_wr_mtime_lo;
    logic                      w_wr_mtime_hi;
    logic                      w_wr_cmp_lo;
    logic                      w_wr_cmp_hi;
    logic                      w_wr_ctrl;
    logic                      w_tick;
    logic [DATA_WIDTH-1:0]     w_ctrl_word;
    logic [DATA_WIDTH-1:0]     w_ctrl_new;
    logic [DATA_WIDTH-1:0]     w_rdata;
    logic [63:0]               w_mtime_nxt;
    logic [63:0]               w_mtimecmp_nxt;
    logic [PRESCALE_WIDTH-1:0] w_pcnt_nxt;

    // Address decode: misaligned offsets fall into the unmapped space.
    assign w_aligned     = (addr_i[1:0] == 2'b00);
    assign w_word        = addr_i[4:2];
    assign w_mapped      = w_aligned && (w_word <= REG_CTRL);
    assign w_is_write    = |we_i;
    assign w_wr          = en_i && w_is_write && w_mapped;
    assign w_rd          = en_i && !w_is_write && w_mapped;
    assign w_wr_mtime_lo = w_wr && (w_word == REG_MTIME_LO);
    assign w_wr_mtime_hi = w_wr && (w_word == REG_MTIME_HI);
    assign w_wr_cmp_lo   = w_wr && (w_word == REG_CMP_LO);
    assign w_wr_cmp_hi   = w_wr && (w_word == REG_CMP_HI);
    assign w_wr_ctrl     = w_wr && (w_word == REG_CTRL);

    // Any CTRL or mtime write steals the tick of its cycle.
    assign w_tick = r_en && (r_pcnt == r_div) && !w_wr_ctrl
                    && !w_wr_mtime_lo && !w_wr_mtime_hi;

    // CTRL as seen on the bus; DIV assumes PRESCALE_WIDTH <= 24.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ctrl_word                       = '0;
        w_ctrl_word[0]                    = r_en;
        w_ctrl_word[8 +: PRESCALE_WIDTH]  = r_div;
    end

    assign w_ctrl_new = merge_bytes(w_ctrl_word, wdata_i, we_i);

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_wr_ctrl) begin
            w_pcnt_nxt = '0;
        end else if (r_en) begin
            w_pcnt_nxt = (r_pcnt == r_div) ? '0 : r_pcnt + PRESCALE_WIDTH'(1);
        end
    end

    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_tick) w_mtime_nxt = r_mtime + 64'd1;
        if (w_wr_mtime_lo) w_mtime_nxt[31:0]  = merge_bytes(r_mtime[31:0], wdata_i, we_i);
        if (w_wr_mtime_hi) w_mtime_nxt[63:32] = merge_bytes(r_mtime[63:32], wdata_i, we_i);
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr_cmp_lo) w_mtimecmp_nxt[31:0]  = merge_bytes(r_mtimecmp[31:0], wdata_i, we_i);
        if (w_wr_cmp_hi) w_mtimecmp_nxt[63:32] = merge_bytes(r_mtimecmp[63:32], wdata_i, we_i);
    end

    // Reads return pre-update values; writes and unmapped accesses return 0.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_word)
                REG_MTIME_LO: w_rdata = r_mtime[31:0];
                REG_MTIME_HI: w_rdata = r_mtime[63:32];
                REG_CMP_LO:   w_rdata = r_mtimecmp[31:0];
                REG_CMP_HI:   w_rdata = r_mtimecmp[63:32];
                REG_CTRL:     w_rdata = w_ctrl_word;
                default:      w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtime      <= '0;
            r_mtimecmp   <= '1;
            r_en         <= 1'b0;
            r_div        <= '0;
            r_pcnt       <= '0;
            rdata_ro     <= '0;
            rvalid_ro    <= 1'b0;
            err_ro       <= 1'b0;
            timer_irq_ro <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_mtime      <= w_mtime_nxt;
            r_mtimecmp   <= w_mtimecmp_nxt;
            r_pcnt       <= w_pcnt_nxt;
            if (w_wr_ctrl) begin
                r_en  <= w_ctrl_new[0];
                r_div <= w_ctrl_new[8 +: PRESCALE_WIDTH];
            end
            rdata_ro     <= w_rdata;
            rvalid_ro    <= en_i;
            err_ro       <= en_i && !w_mapped;
            timer_irq_ro <= r_en && (r_mtime >= r_mtimecmp);
        end
    end

endmodule

// File: tb/tb_jedro_1_mtimer.sv
// Scoreboard bench for jedro_1_mtimer: the driver queues expected responses,
// a negedge monitor pops one per rvalid_ro pulse and compares.
module tb_jedro_1_mtimer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [3:0]  we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_ro;
    logic        rvalid_ro;
    logic        err_ro;
    logic        timer_irq_ro;

    jedro_1_mtimer #(.DATA_WIDTH(32), .PRESCALE_WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_ro     (rdata_ro),
        .rvalid_ro    (rvalid_ro),
        .err_ro       (err_ro),
        .timer_irq_ro (timer_irq_ro)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          id;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_r;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_req    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request for one cycle and queue its expected response.
    task automatic access(input logic [4:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input logic chk_data);
        rsp_t r;
        en_i       = 1'b1;
        addr_i     = addr;
        we_i       = we;
        wdata_i    = wdata;
        r.data     = exp_data;
        r.err      = exp_err;
        r.chk_data = chk_data;
        r.id       = n_req;
        n_req++;
        exp_q.push_back(r);
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        we_i = 4'h0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp_data);
        access(addr, 4'h0, 32'h0, exp_data, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [3:0] we, input logic [31:0] data);
        access(addr, we, data, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic irq_chk(input string name, input logic exp);
        @(negedge clk_i);
        check(name, 64'(timer_irq_ro), 64'(exp));
    endtask

    // Monitor: one queued response per rvalid pulse.
    always @(negedge clk_i) begin
        if (rvalid_ro === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid=1 with no request outstanding");
            end else begin
                mon_r = exp_q.pop_front();
                check($sformatf("rsp%0d_err", mon_r.id), 64'(err_ro), 64'(mon_r.err));
                if (mon_r.chk_data)
                    check($sformatf("rsp%0d_data", mon_r.id), 64'(rdata_ro), 64'(mon_r.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b0;
        we_i    = 4'h0;
        addr_i  = 5'h0;
        wdata_i = 32'h0;
        repeat (2) begin
            @(negedge clk_i);
            check("rst_irq", 64'(timer_irq_ro), 64'd0);
            check("rst_rvalid", 64'(rvalid_ro), 64'd0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset values
        rd(5'h00, 32'h0000_0000);
        rd(5'h04, 32'h0000_0000);
        rd(5'h08, 32'hFFFF_FFFF);
        rd(5'h0C, 32'hFFFF_FFFF);
        rd(5'h10, 32'h0000_0000);
        irq_chk("irq_after_reset", 1'b0);

        // Basic interrupt, DIV=0: ticks on each edge after the CTRL write
        wr(5'h08, 4'hF, 32'd5);
        wr(5'h0C, 4'hF, 32'd0);
        wr(5'h10, 4'hF, 32'h1);
        idle(3);
        rd(5'h00, 32'd3);
        irq_chk("irq_mtime4", 1'b0);
        irq_chk("irq_mtime5", 1'b0);
        irq_chk("irq_rise", 1'b1);
        wr(5'h08, 4'hF, 32'd100);
        irq_chk("irq_hold", 1'b1);
        irq_chk("irq_drop", 1'b0);
        wr(5'h10, 4'hF, 32'h0);
        wr(5'h00, 4'hF, 32'h0);
        wr(5'h04, 4'hF, 32'h0);

        // Prescaler DIV=3: one tick per 4 cycles, restart on CTRL rewrite
        wr(5'h10, 4'hF, 32'h0301);
        idle(40);
        rd(5'h00, 32'd10);
        idle(2);
        wr(5'h10, 4'hF, 32'h0301);
        idle(3);
        rd(5'h00, 32'd10);
        rd(5'h00, 32'd11);
        rd(5'h10, 32'h0301);
        wr(5'h10, 4'hF, 32'h0);

        // 64-bit wrap: exactly one tick between enable and disable
        wr(5'h00, 4'hF, 32'hFFFF_FFFF);
        wr(5'h04, 4'hF, 32'hFFFF_FFFF);
        wr(5'h10, 4'hF, 32'h1);
        idle(1);
        wr(5'h10, 4'hF, 32'h0);
        rd(5'h00, 32'h0);
        rd(5'h04, 32'h0);

        // Carry from low word into high word
        wr(5'h00, 4'hF, 32'hFFFF_FFFF);
        wr(5'h04, 4'hF, 32'h0);
        wr(5'h10, 4'hF, 32'h1);
        idle(1);
        wr(5'h10, 4'hF, 32'h0);
        rd(5'h04, 32'h1);
        rd(5'h00, 32'h0);

        // Byte-lane write of mtime while running suppresses that tick
        wr(5'h00, 4'hF, 32'h1122_3344);
        wr(5'h04, 4'hF, 32'h0);
        wr(5'h10, 4'hF, 32'h1);
        idle(1);
        wr(5'h00, 4'b0010, 32'h0000_AB00);
        wr(5'h10, 4'hF, 32'h0);
        rd(5'h00, 32'h1122_AB45);
        rd(5'h04, 32'h0);

        // CTRL keeps only EN and DIV
        wr(5'h10, 4'hF, 32'hFFFF_FFFF);
        rd(5'h10, 32'h0000_FF01);
        wr(5'h10, 4'hF, 32'h0);

        // Unmapped and misaligned accesses
        access(5'h14, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        access(5'h09, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        access(5'h02, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        access(5'h1C, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        rd(5'h00, 32'h1122_AB45);
        rd(5'h04, 32'h0);
        rd(5'h08, 32'd100);
        rd(5'h0C, 32'h0);
        rd(5'h10, 32'h0);

        // Reset with a simultaneous write: access dropped, write overridden
        en_i    = 1'b1;
        addr_i  = 5'h00;
        we_i    = 4'hF;
        wdata_i = 32'hDEAD_BEEF;
        rst_i   = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_drop_rvalid", 64'(rvalid_ro), 64'd0);
        check("rst_drop_irq", 64'(timer_irq_ro), 64'd0);
        en_i  = 1'b0;
        we_i  = 4'h0;
        rst_i = 1'b0;
        rd(5'h00, 32'h0);
        rd(5'h08, 32'hFFFF_FFFF);
        rd(5'h10, 32'h0);

        // Let the monitor drain, bounded
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_i);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
